// File: rtl/alien_pkg.sv
// Shared constants and types for the alien formation logic.
// Contents: screen geometry (last scan X/Y), default step sizes, march FSM state encoding.
// Imported by the march scheduler and related alien blocks.
package alien_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   // Last visible scan coordinates; the (H_LAST, V_LAST) pixel marks the end of a frame.
   localparam logic [9:0] H_LAST = 10'(SCREEN_W - 1);
   localparam logic [9:0] V_LAST = 10'(SCREEN_H - 1);

   localparam int DEF_STEP_X = 2;
   localparam int DEF_STEP_Y = 8;

   typedef enum logic [2:0] {
      ST_PAUSE   = 3'd0,
      ST_MARCH_R = 3'd1,
      ST_MARCH_L = 3'd2,
      ST_HALT    = 3'd3,
      ST_CLEARED = 3'd4
   } march_state_t;

endpackage

// File: rtl/alien_popcount.sv
// Combinational population count of the alien alive mask.
// Ports: mask (one bit per alien) in; count (number of set bits) out, zero latency.
// Shared by the march scheduler, score and HUD logic.
module alien_popcount #(
   parameter int N  = 16,
   parameter int CW = $clog2(N + 1)
)(
   input  logic [N-1:0]  mask,
   output logic [CW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < N; i++) begin
         count = count + CW'(mask[i]);
      end
   end

endmodule

// File: rtl/alien_march_ctrl.sv
// Alien formation march scheduler: once per march period emits a shared step (X_off, Y_off, step).
// Ports: Pclk/rst (sync, active-high); xx/yy scan position; enable; alive mask; formation extents
//        form_left/right/bottom in; X_off (signed), Y_off, step strobe, dir, sticky invaded/cleared out.
module alien_march_ctrl
   import alien_pkg::*;
#(
   parameter int NUM_ALIENS  = 16,
   parameter int STEP_X      = DEF_STEP_X,
   parameter int STEP_Y      = DEF_STEP_Y,
   parameter int LEFT_LIMIT  = 5,
   parameter int RIGHT_LIMIT = 634,
   parameter int INVADE_Y    = 440,
   parameter int MIN_PERIOD  = 1
)(
   input  logic                  Pclk,
   input  logic                  rst,
   input  logic [9:0]            xx,
   input  logic [9:0]            yy,
   input  logic                  enable,
   input  logic [NUM_ALIENS-1:0] alive,
   input  logic [9:0]            form_left,
   input  logic [9:0]            form_right,
   input  logic [9:0]            form_bottom,
   output logic [9:0]            X_off,
   output logic [9:0]            Y_off,
   output logic                  step,
   output logic                  dir,
   output logic                  invaded,
   output logic                  cleared
);

   localparam int PCW  = $clog2(NUM_ALIENS + 1);
   localparam int PMAX = (MIN_PERIOD > NUM_ALIENS) ? MIN_PERIOD : NUM_ALIENS;
   localparam int CW   = $clog2(PMAX + 1);

   march_state_t   state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [CW-1:0]  period;
   logic [PCW-1:0] live_cnt;
   logic           dir_nxt, step_nxt, inv_nxt, clr_nxt;
   logic [9:0]     x_nxt, y_nxt;

   logic frame_tick, step_due, right_edge, left_edge, at_edge, drop_invades, no_alive, take_step;

   alien_popcount #(.N(NUM_ALIENS), .CW(PCW)) u_popcount (
      .mask  (alive),
      .count (live_cnt)
   );

   // Fewer live aliens -> shorter period -> faster march.
   assign period = (CW'(live_cnt) < CW'(MIN_PERIOD)) ? CW'(MIN_PERIOD) : CW'(live_cnt);

   assign frame_tick = (xx == H_LAST) && (yy == V_LAST);
   // ">=" rather than "==" so a period that shrank below the running count fires at the next tick.
   assign step_due   = frame_tick && (cnt >= period - CW'(1));

   // Extent sums at 11 bits so an edge near the right limit cannot wrap.
   assign right_edge   = ({1'b0, form_right} + 11'(STEP_X)) > 11'(RIGHT_LIMIT);
   assign left_edge    = {1'b0, form_left} < 11'(LEFT_LIMIT + STEP_X);
   assign at_edge      = (state == ST_MARCH_R) ? right_edge : left_edge;
   assign drop_invades = ({1'b0, form_bottom} + 11'(STEP_Y)) >= 11'(INVADE_Y);
   assign no_alive     = (alive == '0);

   // An invading drop outranks a pause request, so it is still taken with enable low.
   assign take_step = step_due && (enable || (at_edge && drop_invades));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dir_nxt   = dir;
      step_nxt  = 1'b0;
      x_nxt     = '0;
      y_nxt     = '0;
      inv_nxt   = invaded;
      clr_nxt   = cleared;
      case (state)
         ST_HALT, ST_CLEARED: begin
         end
         default: begin
            if (no_alive) begin
               state_nxt = ST_CLEARED;
               clr_nxt   = 1'b1;
            end else if (state == ST_PAUSE) begin
               if (enable) begin
                  state_nxt = dir ? ST_MARCH_R : ST_MARCH_L;
               end
            end else if (take_step) begin
               cnt_nxt  = '0;
               step_nxt = 1'b1;
               if (at_edge) begin
                  y_nxt     = 10'(STEP_Y);
                  dir_nxt   = (state == ST_MARCH_L);
                  state_nxt = dir_nxt ? ST_MARCH_R : ST_MARCH_L;
                  if (drop_invades) begin
                     state_nxt = ST_HALT;
                     inv_nxt   = 1'b1;
                  end
               end else begin
                  x_nxt = (state == ST_MARCH_R) ? 10'(STEP_X) : 10'(-STEP_X);
               end
            end else if (!enable) begin
               state_nxt = ST_PAUSE;
            end else if (frame_tick) begin
               cnt_nxt = cnt + CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge Pclk) begin
      if (rst) begin
         state   <= ST_PAUSE;
         cnt     <= '0;
         dir     <= 1'b1;
         step    <= 1'b0;
         X_off   <= '0;
         Y_off   <= '0;
         invaded <= 1'b0;
         cleared <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         dir     <= dir_nxt;
         step    <= step_nxt;
         X_off   <= x_nxt;
         Y_off   <= y_nxt;
         invaded <= inv_nxt;
         cleared <= clr_nxt;
      end
   end

endmodule
